uart_mmio_responder: RTL and testbench

//  Memory-mapped UART responder at 0x8000_00xx; target of the REUART/WEUART strobes issued by Control.

---
 rtl/uart_mmio_pkg.sv | 40 ++++
 rtl/uart_rx_fifo.sv | 57 +++++
 rtl/uart_mmio_responder.sv | 143 ++++++++++++++
 tb/tb_uart_mmio_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared address map, STATUS bit positions and register-select decode for the
// memory-mapped UART responder at 0x8000_00xx.
package uart_mmio_pkg;

    localparam logic [23:0] UART_BASE     = 24'h800000;

    localparam logic [7:0]  OFF_STATUS    = 8'h00;
    localparam logic [7:0]  OFF_RX_DATA   = 8'h04;
    localparam logic [7:0]  OFF_TX_DATA   = 8'h08;
    localparam logic [7:0]  OFF_CYCLE     = 8'h10;
    localparam logic [7:0]  OFF_CYCLE_CLR = 8'h18;

    localparam int ST_TX_READY   = 0;
    localparam int ST_RX_VALID   = 1;
    localparam int ST_TX_OVERRUN = 2;
    localparam int ST_RX_COUNT   = 8;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_STATUS,
        SEL_RX_DATA,
        SEL_TX_DATA,
        SEL_CYCLE,
        SEL_CYCLE_CLR
    } reg_sel_e;

    function automatic reg_sel_e decode_offset(input logic [7:0] off);
        reg_sel_e sel;
        case (off)
            OFF_STATUS:    sel = SEL_STATUS;
            OFF_RX_DATA:   sel = SEL_RX_DATA;
            OFF_TX_DATA:   sel = SEL_TX_DATA;
            OFF_CYCLE:     sel = SEL_CYCLE;
            OFF_CYCLE_CLR: sel = SEL_CYCLE_CLR;
            default:       sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: push/pop with full/empty and an occupancy count one bit wider
// than the pointers. Push on full and pop on empty are ignored.
module uart_rx_fifo
    import uart_mmio_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_pop_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/uart_mmio_responder.sv
// CPU-facing UART register block: RX FIFO, single TX holding register, STATUS.
// Optional 32-bit cycle counter at 0x10/0x18 enabled by UART_CYCLE_COUNTER_EN.
module uart_mmio_responder
    import uart_mmio_pkg::*;
#(
    parameter int RX_DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_address,
    input  logic [31:0] i_write_data,
    input  logic        i_reuart,
    input  logic        i_weuart,
    output logic [31:0] o_read_data,
    output logic [7:0]  o_data_in,
    output logic        o_data_in_valid,
    input  logic        i_data_in_ready,
    input  logic [7:0]  i_data_out,
    input  logic        i_data_out_valid,
    output logic        o_data_out_ready
);

    localparam int RX_AW = $clog2(RX_DEPTH);

    logic [31:0]    r_read_data;
    logic [7:0]     r_tx_reg;
    logic           r_tx_full;
    logic           r_tx_overrun;

    logic           w_hit;
    reg_sel_e       w_sel;
    logic           w_rd;
    logic           w_wr;
    logic           w_tx_wr;
    logic           w_tx_accept;
    logic           w_status_rd;
    logic           w_pop;
    logic           w_push;
    logic [7:0]     w_rx_data;
    logic           w_rx_full;
    logic           w_rx_empty;
    logic [RX_AW:0] w_rx_count;
    logic [31:0]    w_status;
    logic [31:0]    w_cycle;
    logic [31:0]    w_rd_value;
    logic           w_unused_wdata;

    assign w_hit          = (i_address[31:8] == UART_BASE);
    assign w_sel          = decode_offset(i_address[7:0]);
    assign w_rd           = i_reuart && w_hit;
    assign w_wr           = i_weuart && w_hit;
    assign w_tx_wr        = w_wr && (w_sel == SEL_TX_DATA);
    assign w_tx_accept    = w_tx_wr && (!r_tx_full || i_data_in_ready);
    assign w_status_rd    = w_rd && (w_sel == SEL_STATUS);
    assign w_pop          = w_rd && (w_sel == SEL_RX_DATA);
    assign w_push         = i_data_out_valid && !w_rx_full;
    assign w_unused_wdata = ^i_write_data[31:8];

    assign o_read_data      = r_read_data;
    assign o_data_in        = r_tx_reg;
    assign o_data_in_valid  = r_tx_full;
    assign o_data_out_ready = !w_rx_full;

    uart_rx_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push),
        .i_push_data (i_data_out),
        .i_pop       (w_pop),
        .o_pop_data  (w_rx_data),
        .o_full      (w_rx_full),
        .o_empty     (w_rx_empty),
        .o_count     (w_rx_count)
    );

`ifdef UART_CYCLE_COUNTER_EN
    logic [31:0] r_cycle;

    // A clear write takes priority over the free-running increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cycle <= '0;
        end else if (w_wr && (w_sel == SEL_CYCLE_CLR)) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    assign w_cycle = r_cycle;
`else
    assign w_cycle = '0;
`endif

    always_comb begin
        w_status                      = '0;
        w_status[ST_TX_READY]         = !r_tx_full;
        w_status[ST_RX_VALID]         = !w_rx_empty;
        w_status[ST_TX_OVERRUN]       = r_tx_overrun;
        w_status[ST_RX_COUNT +: 8]    = 8'(w_rx_count);
    end

    // An empty FIFO read returns zero; the FIFO itself ignores the pop.
    always_comb begin
        w_rd_value = '0;
        case (w_sel)
            SEL_STATUS:  w_rd_value = w_status;
            SEL_RX_DATA: w_rd_value = w_rx_empty ? 32'd0 : {24'd0, w_rx_data};
            SEL_CYCLE:   w_rd_value = w_cycle;
            default:     w_rd_value = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_read_data  <= '0;
            r_tx_full    <= 1'b0;
            r_tx_overrun <= 1'b0;
        end else begin
            if (w_rd) r_read_data <= w_rd_value;

            if (w_tx_accept) begin
                r_tx_full <= 1'b1;
            end else if (r_tx_full && i_data_in_ready) begin
                r_tx_full <= 1'b0;
            end

            if (w_tx_wr && !w_tx_accept) begin
                r_tx_overrun <= 1'b1;
            end else if (w_status_rd) begin
                r_tx_overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_tx_accept) r_tx_reg <= i_write_data[7:0];
    end

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Scoreboarded bench for uart_mmio_responder: directed CPU/RX/TX vectors, read
// data checked by a monitor one cycle after each REUART hit.
module tb_uart_mmio_responder;

    localparam logic [31:0] A_STATUS = 32'h8000_0000;
    localparam logic [31:0] A_RX     = 32'h8000_0004;
    localparam logic [31:0] A_TX     = 32'h8000_0008;
    localparam logic [31:0] A_UNMAP  = 32'h8000_000C;
    localparam logic [31:0] A_CYCLE  = 32'h8000_0010;
    localparam logic [31:0] A_CLR    = 32'h8000_0018;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        reuart;
    logic        weuart;
    logic [31:0] read_data;
    logic [7:0]  data_in;
    logic        data_in_valid;
    logic        data_in_ready;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic        data_out_ready;

    logic [31:0] q_exp [$];
    bit          q_chk [$];
    string       q_name[$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    uart_mmio_responder #(.RX_DEPTH(8)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_address        (address),
        .i_write_data     (write_data),
        .i_reuart         (reuart),
        .i_weuart         (weuart),
        .o_read_data      (read_data),
        .o_data_in        (data_in),
        .o_data_in_valid  (data_in_valid),
        .i_data_in_ready  (data_in_ready),
        .i_data_out       (data_out),
        .i_data_out_valid (data_out_valid),
        .o_data_out_ready (data_out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus cycle: inputs applied after a falling edge, removed at the next.
    task automatic step(input bit push, input logic [7:0] pb, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp, input bit chk, input string name);
        data_out       = pb;
        data_out_valid = push;
        reuart         = rd;
        weuart         = wr;
        address        = addr;
        write_data     = wd;
        if (rd) begin
            q_exp.push_back(exp);
            q_chk.push_back(chk);
            q_name.push_back(name);
        end
        @(negedge clk);
        data_out_valid = 1'b0;
        reuart         = 1'b0;
        weuart         = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        step(1'b0, 8'h00, 1'b1, 1'b0, addr, 32'h0, exp, 1'b1, name);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
        step(1'b0, 8'h00, 1'b0, 1'b1, addr, wd, 32'h0, 1'b0, "");
    endtask

    task automatic rx(input logic [7:0] b);
        step(1'b1, b, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, "");
    endtask

    // Monitor: a read hit sampled at a rising edge must appear on ReadData just after it.
    initial begin
        logic        pend;
        logic [31:0] e;
        bit          c;
        string       nm;
        forever begin
            @(posedge clk);
            pend = reuart && (address[31:8] == 24'h800000) && rst_n;
            #1;
            if (pend) begin
                if (q_exp.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_read: got 0x%08h, expected no read", read_data);
                end else begin
                    e  = q_exp.pop_front();
                    c  = q_chk.pop_front();
                    nm = q_name.pop_front();
                    if (c) check(nm, read_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v1, v2, v3;
        rst_n          = 1'b0;
        address        = '0;
        write_data     = '0;
        reuart         = 1'b0;
        weuart         = 1'b0;
        data_in_ready  = 1'b0;
        data_out       = '0;
        data_out_valid = 1'b0;
        v1 = '0; v2 = '0; v3 = '0;
        repeat (2) @(negedge clk);
        check("rst_data_in_valid", 32'(data_in_valid), 32'h0);
        check("rst_data_out_ready", 32'(data_out_ready), 32'h1);
        check("rst_read_data", read_data, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // TX load, then overrun on a second write while pending
        wr(A_TX, 32'hDEAD_BE41);
        check("tx_valid", 32'(data_in_valid), 32'h1);
        check("tx_data", 32'(data_in), 32'h41);
        rd(A_STATUS, 32'h0000_0000, "status_tx_full");
        wr(A_TX, 32'h0000_0042);
        check("tx_data_kept", 32'(data_in), 32'h41);
        rd(A_STATUS, 32'h0000_0004, "status_overrun");
        rd(A_STATUS, 32'h0000_0000, "status_overrun_cleared");
        data_in_ready = 1'b1;
        wr(A_TX, 32'h0000_0042);
        data_in_ready = 1'b0;
        check("tx_refill_valid", 32'(data_in_valid), 32'h1);
        check("tx_refill_data", 32'(data_in), 32'h42);
        data_in_ready = 1'b1;
        @(negedge clk);
        data_in_ready = 1'b0;
        check("tx_drained", 32'(data_in_valid), 32'h0);
        rd(A_STATUS, 32'h0000_0001, "status_tx_ready");

        // RX ordering and empty read
        rx(8'h10); rx(8'h11); rx(8'h12);
        rd(A_STATUS, 32'h0000_0303, "status_rx3");
        rd(A_RX, 32'h10, "rx0");
        rd(A_RX, 32'h11, "rx1");
        rd(A_RX, 32'h12, "rx2");
        rd(A_RX, 32'h00, "rx_empty");
        rd(A_STATUS, 32'h0000_0001, "status_rx0");

        // Fill to full, pop, simultaneous push/pop, refill
        for (int i = 0; i < 8; i++) rx(8'(8'h20 + i));
        check("full_ready", 32'(data_out_ready), 32'h0);
        rd(A_STATUS, 32'h0000_0803, "status_full");
        rd(A_RX, 32'h20, "pop_full");
        check("ready_after_pop", 32'(data_out_ready), 32'h1);
        step(1'b1, 8'h28, 1'b1, 1'b0, A_RX, 32'h0, 32'h21, 1'b1, "pushpop_7");
        rd(A_STATUS, 32'h0000_0703, "status_7");
        rx(8'h29);
        check("refull_ready", 32'(data_out_ready), 32'h0);
        rd(A_STATUS, 32'h0000_0803, "status_refull");
        for (int i = 0; i < 8; i++) rd(A_RX, 32'(8'h22 + i), "drain");

        // Wrap: 20 bytes through the FIFO in order
        for (int i = 0; i < 4; i++) rx(8'(8'h60 + i));
        for (int i = 0; i < 16; i++)
            step(1'b1, 8'(8'h64 + i), 1'b1, 1'b0, A_RX, 32'h0, 32'(8'h60 + i), 1'b1, "wrap_pp");
        for (int i = 0; i < 4; i++) rd(A_RX, 32'(8'h70 + i), "wrap_tail");

        // Empty FIFO: push and pop together, no bypass
        step(1'b1, 8'h55, 1'b1, 1'b0, A_RX, 32'h0, 32'h00, 1'b1, "empty_pushpop");
        rd(A_STATUS, 32'h0000_0103, "status_after_pp");
        rd(A_RX, 32'h55, "rx_55");

        // Async reset during a TX handshake
        rx(8'h99);
        wr(A_TX, 32'h77);
        check("tx_pending", 32'(data_in_valid), 32'h1);
        data_in_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(data_in_valid), 32'h0);
        check("async_rst_read_data", read_data, 32'h0);
        check("async_rst_ready", 32'(data_out_ready), 32'h1);
        @(negedge clk);
        data_in_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(A_STATUS, 32'h0000_0001, "status_post_rst");

        // Decode misses and unmapped offsets
        wr(32'h9000_0008, 32'h33);
        check("miss_write_ignored", 32'(data_in_valid), 32'h0);
        rd(A_UNMAP, 32'h0, "unmapped_read");
        rd(A_STATUS, 32'h0000_0001, "status_again");

`ifdef UART_CYCLE_COUNTER_EN
        step(1'b0, 8'h00, 1'b1, 1'b0, A_CYCLE, 32'h0, 32'h0, 1'b0, "cyc1");
        v1 = read_data;
        repeat (4) @(negedge clk);
        step(1'b0, 8'h00, 1'b1, 1'b0, A_CYCLE, 32'h0, 32'h0, 1'b0, "cyc2");
        v2 = read_data;
        check("cycle_delta", v2 - v1, 32'd5);
        wr(A_CLR, 32'h0);
        step(1'b0, 8'h00, 1'b1, 1'b0, A_CYCLE, 32'h0, 32'h0, 1'b0, "cyc3");
        v3 = read_data;
        check("cycle_after_clear", v3, 32'd0);
`else
        rd(A_CYCLE, 32'h0, "cycle_disabled");
        wr(A_CLR, 32'h0);
        rd(A_CYCLE, 32'h0, "cycle_disabled_after_clr");
`endif

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(q_exp.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
